// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO word serializer.
package fifo_ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } ser_state_e;

  localparam logic FRAME_START_BIT = 1'b0;
  localparam logic FRAME_STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE       = 1'b1;

  localparam int unsigned WORDS_W = 16;

  // Clock cycles of line activity for one complete frame.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned parity_en,
                                            input int unsigned bit_cycles);
    return (2 + data_w + parity_en) * bit_cycles;
  endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-period down-counter: tick marks the last cycle of each serial bit.
module ser_bit_timer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick_c,
  output logic pre_tick_c
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Reload on frame start or at each bit boundary, otherwise count down.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load || (cnt == '0)) begin
      cnt <= CNT_MAX;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tick_c     = (cnt == '0);
  // One cycle ahead of tick; never fires when every cycle is a tick.
  assign pre_tick_c = (BIT_CYCLES > 1) && (cnt == CNT_W'(1));

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a FIFO and sends each as a start/data/parity/stop frame.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BIT_CYCLES = 4,
  parameter bit          PARITY_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               fifo_empty,
  input  logic [DATA_W-1:0]  fifo_data,
  output logic               fifo_pop,
  output logic               sout,
  output logic               busy,
  output logic               frame_done,
  output logic [WORDS_W-1:0] words_sent
);

  localparam int unsigned BCNT_W = $clog2(DATA_W);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
  // With single-cycle bits the stop bit's only cycle is also its last.
  localparam logic DONE_ON_ENTRY = (BIT_CYCLES == 1);

  ser_state_e        state;
  logic [DATA_W-1:0] shreg;
  logic [BCNT_W-1:0] bit_cnt;
  logic              parity;
  logic              tick_c;
  logic              pre_tick_c;
  logic              launch_c;

  assign launch_c = en && !fifo_empty;

  ser_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (state == WAIT),
    .tick_c     (tick_c),
    .pre_tick_c (pre_tick_c)
  );

  // Frame sequencer with registered line, handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      parity     <= 1'b0;
      sout       <= LINE_IDLE;
      fifo_pop   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      words_sent <= '0;
    end else begin
      fifo_pop   <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch_c) begin
            state    <= POP;
            fifo_pop <= 1'b1;
            busy     <= 1'b1;
          end
        end
        POP: begin
          state <= WAIT;
        end
        WAIT: begin
          shreg   <= fifo_data;
          parity  <= ^fifo_data;
          bit_cnt <= '0;
          sout    <= FRAME_START_BIT;
          state   <= START;
        end
        START: begin
          if (tick_c) begin
            sout  <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick_c) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN) begin
                sout  <= parity;
                state <= PARITY;
              end else begin
                sout       <= FRAME_STOP_BIT;
                state      <= STOP;
                frame_done <= DONE_ON_ENTRY;
              end
            end else begin
              shreg   <= shreg >> 1;
              sout    <= shreg[1];
              bit_cnt <= bit_cnt + BCNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (tick_c) begin
            sout       <= FRAME_STOP_BIT;
            state      <= STOP;
            frame_done <= DONE_ON_ENTRY;
          end
        end
        STOP: begin
          if (pre_tick_c) begin
            frame_done <= 1'b1;
          end
          if (tick_c) begin
            words_sent <= words_sent + WORDS_W'(1);
            if (launch_c) begin
              state    <= POP;
              fifo_pop <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          sout  <= LINE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: FIFO model, serial-line decoder, scoreboard.
module tb_fifo_word_serializer;

  typedef struct packed {
    logic [15:0] data;
    logic        par;
    logic        start_ok;
    logic        stop_ok;
    logic        stable;
    logic [7:0]  fd_cnt;
    logic [7:0]  fd_pos;
    logic [7:0]  gap;
  } rec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic en0   = 1'b0;
  logic en1   = 1'b0;
  logic empty0, empty1;
  logic [15:0] data0 = '0;
  logic [15:0] data1 = '0;
  logic pop0, pop1, sout0, sout1, busy0, busy1, fd0, fd1;
  logic [15:0] ws0, ws1;

  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];
  int unsigned wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  rec_t got0[$];
  rec_t got1[$];

  rec_t cur  [2];
  logic act  [2];
  int   cyc  [2];
  int   idle [2];
  logic prv  [2];
  logic bitv [2];

  int pops0     = 0;
  int pop_empty = 0;
  int fd_stray  = 0;
  int n_tests   = 0;
  int n_fail    = 0;
  int ws_exp0   = 0;

  assign empty0 = (wr0 == rd0);
  assign empty1 = (wr1 == rd1);

  always #5 clk = ~clk;

  fifo_word_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en0),
    .fifo_empty (empty0),
    .fifo_data  (data0),
    .fifo_pop   (pop0),
    .sout       (sout0),
    .busy       (busy0),
    .frame_done (fd0),
    .words_sent (ws0)
  );

  fifo_word_serializer #(.DATA_W(16), .BIT_CYCLES(4), .PARITY_EN(1'b0)) dut_np (
    .clk        (clk),
    .reset      (reset),
    .en         (en1),
    .fifo_empty (empty1),
    .fifo_data  (data1),
    .fifo_pop   (pop1),
    .sout       (sout1),
    .busy       (busy1),
    .frame_done (fd1),
    .words_sent (ws1)
  );

  // FIFO model: read data valid the cycle after a pop.
  always @(posedge clk) begin
    if (pop0) begin
      if (empty0) pop_empty <= pop_empty + 1;
      data0 <= mem0[rd0 % 64];
      rd0   <= rd0 + 1;
    end
    if (pop1) begin
      if (empty1) pop_empty <= pop_empty + 1;
      data1 <= mem1[rd1 % 64];
      rd1   <= rd1 + 1;
    end
  end

  always @(negedge clk) begin
    if (reset && pop0) pops0 = pops0 + 1;
  end

  // Line decoder: frames start on a falling edge; bits sampled mid-period.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic s, f;
      int nb, bi, ph;
      s  = (k == 0) ? sout0 : sout1;
      f  = (k == 0) ? fd0 : fd1;
      nb = (k == 0) ? 19 : 18;
      if (!reset) begin
        act[k]  = 1'b0;
        idle[k] = 0;
        prv[k]  = 1'b1;
      end else begin
        if (!act[k]) begin
          if (prv[k] && !s) begin
            act[k]        = 1'b1;
            cyc[k]        = 0;
            cur[k]        = '0;
            cur[k].stable = 1'b1;
            cur[k].gap    = 8'(idle[k]);
          end else begin
            if (s) idle[k] = idle[k] + 1;
            if (f) fd_stray = fd_stray + 1;
          end
        end else begin
          cyc[k] = cyc[k] + 1;
        end
        if (act[k]) begin
          bi = cyc[k] / 4;
          ph = cyc[k] % 4;
          if (ph == 0) bitv[k] = s;
          else if (s !== bitv[k]) cur[k].stable = 1'b0;
          if (ph == 2) begin
            if (bi == 0) cur[k].start_ok = (s === 1'b0);
            else if (bi <= 16) cur[k].data[bi-1] = s;
            else if (bi == nb - 1) cur[k].stop_ok = (s === 1'b1);
            else cur[k].par = s;
          end
          if (f) begin
            cur[k].fd_cnt = cur[k].fd_cnt + 8'd1;
            cur[k].fd_pos = 8'(cyc[k]);
          end
          if (cyc[k] == nb * 4 - 1) begin
            if (k == 0) got0.push_back(cur[k]);
            else got1.push_back(cur[k]);
            act[k]  = 1'b0;
            idle[k] = 0;
          end
        end
      end
      prv[k] = s;
    end
  end

  task automatic push0(input logic [15:0] w);
    mem0[wr0 % 64] = w;
    wr0 = wr0 + 1;
    exp0.push_back(w);
  endtask

  task automatic push1(input logic [15:0] w);
    mem1[wr1 % 64] = w;
    wr1 = wr1 + 1;
    exp1.push_back(w);
  endtask

  task automatic wait_frames(input int k, input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (((k == 0) ? got0.size() : got1.size()) < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    ok = (((k == 0) ? got0.size() : got1.size()) >= n);
  endtask

  task automatic wait_mid_data(input int min_cyc, output bit ok);
    int t;
    t = 0;
    while (!(act[0] && cyc[0] >= min_cyc) && t < 400) begin
      @(negedge clk);
      t++;
    end
    ok = act[0] && cyc[0] >= min_cyc;
  endtask

  task automatic test_reset();
    en0 = 1'b1;
    push0(16'hA5C3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (sout0 !== 1'b1 || pop0 !== 1'b0 || busy0 !== 1'b0 || ws0 !== 16'd0 || fd0 !== 1'b0) begin
        $display("FAIL reset_state cyc=%0d sout=%b pop=%b busy=%b ws=%0d fd=%b, want 1 0 0 0 0",
                 i, sout0, pop0, busy0, ws0, fd0);
        n_fail++;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (pop0 !== 1'b1 || busy0 !== 1'b1) begin
      $display("FAIL first_pop pop=%b busy=%b, want 1 1", pop0, busy0);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (pop0 !== 1'b0) begin
      $display("FAIL pop_width pop=%b, want 0", pop0);
      n_fail++;
    end
  endtask

  task automatic test_single_word();
    bit ok;
    rec_t r;
    logic [15:0] w;
    wait_frames(0, 1, 300, ok);
    n_tests++;
    if (!ok) begin
      $display("FAIL single_timeout frames=%0d, want 1", got0.size());
      n_fail++;
    end else begin
      r = got0.pop_front();
      w = exp0.pop_front();
      ws_exp0++;
      n_tests++;
      if (r.data !== w) begin
        $display("FAIL single_data got=%h want=%h", r.data, w);
        n_fail++;
      end
      n_tests++;
      if (r.par !== 1'b0) begin
        $display("FAIL single_parity got=%b want=0", r.par);
        n_fail++;
      end
      n_tests++;
      if (!r.start_ok || !r.stop_ok || !r.stable) begin
        $display("FAIL single_framing start=%b stop=%b stable=%b, want 1 1 1", r.start_ok, r.stop_ok, r.stable);
        n_fail++;
      end
      n_tests++;
      if (r.fd_cnt !== 8'd1 || r.fd_pos !== 8'd75) begin
        $display("FAIL single_frame_done cnt=%0d pos=%0d, want 1 75", r.fd_cnt, r.fd_pos);
        n_fail++;
      end
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (ws0 !== 16'(ws_exp0) || busy0 !== 1'b0) begin
      $display("FAIL single_count ws=%0d busy=%b, want %0d 0", ws0, busy0, ws_exp0);
      n_fail++;
    end
  endtask

  task automatic test_parity();
    bit ok;
    rec_t r;
    logic [15:0] w;
    push0(16'h0001);
    wait_frames(0, 1, 300, ok);
    n_tests++;
    if (!ok) begin
      $display("FAIL parity_timeout frames=%0d, want 1", got0.size());
      n_fail++;
    end else begin
      r = got0.pop_front();
      w = exp0.pop_front();
      ws_exp0++;
      n_tests++;
      if (r.data !== w || r.par !== 1'b1 || r.fd_pos !== 8'd75 || !r.stop_ok) begin
        $display("FAIL parity_on data=%h par=%b fd_pos=%0d stop=%b, want %h 1 75 1",
                 r.data, r.par, r.fd_pos, r.stop_ok, w);
        n_fail++;
      end
    end
    push1(16'h0001);
    en1 = 1'b1;
    wait_frames(1, 1, 300, ok);
    en1 = 1'b0;
    n_tests++;
    if (!ok) begin
      $display("FAIL noparity_timeout frames=%0d, want 1", got1.size());
      n_fail++;
    end else begin
      r = got1.pop_front();
      w = exp1.pop_front();
      n_tests++;
      if (r.data !== w || !r.start_ok || !r.stop_ok || !r.stable || r.fd_cnt !== 8'd1 || r.fd_pos !== 8'd71) begin
        $display("FAIL noparity_frame data=%h stop=%b stable=%b fd_cnt=%0d fd_pos=%0d, want %h 1 1 1 71",
                 r.data, r.stop_ok, r.stable, r.fd_cnt, r.fd_pos, w);
        n_fail++;
      end
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if (ws1 !== 16'd1 || ws0 !== 16'(ws_exp0)) begin
      $display("FAIL parity_counts ws_np=%0d ws=%0d, want 1 %0d", ws1, ws0, ws_exp0);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    rec_t r;
    logic [15:0] w;
    int base;
    base = pops0;
    push0(16'h1234);
    push0(16'hFFFF);
    push0(16'h8000);
    wait_frames(0, 3, 800, ok);
    n_tests++;
    if (!ok) begin
      $display("FAIL b2b_timeout frames=%0d, want 3", got0.size());
      n_fail++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r = got0.pop_front();
        w = exp0.pop_front();
        ws_exp0++;
        n_tests++;
        if (r.data !== w || r.par !== ^w || !r.start_ok || !r.stop_ok || !r.stable ||
            r.fd_cnt !== 8'd1 || r.fd_pos !== 8'd75) begin
          $display("FAIL b2b_frame%0d data=%h par=%b stable=%b fd_pos=%0d, want %h %b 1 75",
                   i, r.data, r.par, r.stable, r.fd_pos, w, ^w);
          n_fail++;
        end
        if (i > 0) begin
          n_tests++;
          if (r.gap !== 8'd2) begin
            $display("FAIL b2b_gap%0d got=%0d want=2", i, r.gap);
            n_fail++;
          end
        end
      end
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (pops0 - base !== 3 || ws0 !== 16'(ws_exp0) || busy0 !== 1'b0 || pop_empty !== 0) begin
      $display("FAIL b2b_counts pops=%0d ws=%0d busy=%b pop_empty=%0d, want 3 %0d 0 0",
               pops0 - base, ws0, busy0, pop_empty, ws_exp0);
      n_fail++;
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    rec_t r;
    logic [15:0] w;
    int base;
    base = pops0;
    push0(16'h0F0F);
    push0(16'h3333);
    push0(16'h5A5A);
    wait_mid_data(12, ok);
    en0 = 1'b0;
    n_tests++;
    if (!ok) begin
      $display("FAIL endrop_start frame not seen, want active frame");
      n_fail++;
    end
    wait_frames(0, 1, 300, ok);
    repeat (150) @(negedge clk);
    n_tests++;
    if (!ok || got0.size() !== 1 || pops0 - base !== 1) begin
      $display("FAIL endrop_hold frames=%0d pops=%0d, want 1 1", got0.size(), pops0 - base);
      n_fail++;
    end
    if (got0.size() > 0) begin
      r = got0.pop_front();
      w = exp0.pop_front();
      ws_exp0++;
      n_tests++;
      if (r.data !== w || r.fd_pos !== 8'd75) begin
        $display("FAIL endrop_frame data=%h fd_pos=%0d, want %h 75", r.data, r.fd_pos, w);
        n_fail++;
      end
    end
    en0 = 1'b1;
    wait_frames(0, 2, 800, ok);
    n_tests++;
    if (!ok) begin
      $display("FAIL endrop_resume frames=%0d, want 2", got0.size());
      n_fail++;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r = got0.pop_front();
        w = exp0.pop_front();
        ws_exp0++;
        n_tests++;
        if (r.data !== w || r.par !== ^w || !r.stable) begin
          $display("FAIL endrop_resume%0d data=%h par=%b, want %h %b", i, r.data, r.par, w, ^w);
          n_fail++;
        end
      end
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (pops0 - base !== 3 || ws0 !== 16'(ws_exp0)) begin
      $display("FAIL endrop_counts pops=%0d ws=%0d, want 3 %0d", pops0 - base, ws0, ws_exp0);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rec_t r;
    logic [15:0] w;
    push0(16'hC0DE);
    push0(16'hBEEF);
    wait_mid_data(24, ok);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (!ok || sout0 !== 1'b1 || ws0 !== 16'd0 || busy0 !== 1'b0 || pop0 !== 1'b0) begin
      $display("FAIL midreset_state seen=%b sout=%b ws=%0d busy=%b pop=%b, want 1 1 0 0 0",
               ok, sout0, ws0, busy0, pop0);
      n_fail++;
    end
    void'(exp0.pop_front());
    ws_exp0 = 0;
    @(negedge clk);
    reset = 1'b1;
    wait_frames(0, 1, 300, ok);
    n_tests++;
    if (!ok) begin
      $display("FAIL midreset_timeout frames=%0d, want 1", got0.size());
      n_fail++;
    end else begin
      r = got0.pop_front();
      w = exp0.pop_front();
      ws_exp0++;
      n_tests++;
      if (r.data !== w || !r.start_ok || !r.stop_ok || !r.stable || r.fd_pos !== 8'd75) begin
        $display("FAIL midreset_frame data=%h stable=%b fd_pos=%0d, want %h 1 75", r.data, r.stable, r.fd_pos, w);
        n_fail++;
      end
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (ws0 !== 16'(ws_exp0) || fd_stray !== 0 || pop_empty !== 0 || got0.size() !== 0) begin
      $display("FAIL midreset_counts ws=%0d stray_fd=%0d pop_empty=%0d extra=%0d, want %0d 0 0 0",
               ws0, fd_stray, pop_empty, got0.size(), ws_exp0);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_parity();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
Downstream consumer of the 16-bit synchronous FIFO. Pops one word at a time and transmits it on a single-wire serial line as a framed word: start bit, 16 data bits LSB-first, optional even parity, stop bit.
Rate-decouples the FIFO's word-parallel stream from a slow serial link. Reports per-frame completion and a running word count.

Parameters:
DATA_W, 16, word width; matches the FIFO data width.
BIT_CYCLES, 4, clk cycles per serial bit (>=1).
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = omit it.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
en  input  1  enable for starting new frames
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_W  FIFO read data, valid the cycle after fifo_pop
fifo_pop  output  1  one-cycle pop request to the FIFO
sout  output  1  serial line; idles high
busy  output  1  high from POP state through the end of STOP
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit
words_sent  output  16  count of completed frames

Behaviour:
- Reset: the module samples reset==0 on a clk edge. On that edge it enters IDLE and drives sout=1, fifo_pop=0, busy=0, frame_done=0 and words_sent=0. It clears the shift register and the bit and cycle counters.
- Reset mid-frame aborts the frame immediately; no partial stop bit is sent.
- FSM states: IDLE, POP, WAIT, START, DATA, PARITY, STOP.
- IDLE: when en=1 and fifo_empty=0 are sampled, go to POP. Otherwise stay in IDLE.
- POP: fifo_pop = (state==POP), high for exactly one cycle. Next state is WAIT.
- WAIT: the FIFO presents the popped word. Capture fifo_data into the shift register and compute parity = ^fifo_data. Go to START.
- Latency: from the en & !fifo_empty sampling edge to sout falling is 3 clk edges.
- START: sout=0 for BIT_CYCLES cycles.
- DATA: sout = shreg[0]. Shift right every BIT_CYCLES cycles. A bit counter runs 0..DATA_W-1; after the last bit, go to PARITY if PARITY_EN, else STOP.
- PARITY: sout = even-parity bit (XOR of all data bits) for BIT_CYCLES cycles.
- STOP: sout=1 for BIT_CYCLES cycles.
  - frame_done=1 on the final cycle of STOP, and words_sent increments on that edge. words_sent wraps 16'hFFFF to 0.
  - On STOP exit, if en=1 and fifo_empty=0, go straight to POP (back-to-back frames with no idle gap beyond POP and WAIT). Otherwise go to IDLE.
- Frame length: (2 + DATA_W + PARITY_EN) * BIT_CYCLES cycles of sout activity, i.e. 76 with the defaults.
- en deasserted mid-frame: the current frame completes normally. No new pop occurs.
- fifo_pop is never asserted while fifo_empty=1; the check is made at the IDLE/STOP exit decision.
- fifo_empty rising during a frame has no effect on the frame in flight.
- A cycle counter 0..BIT_CYCLES-1 generates the bit tick. With BIT_CYCLES=1 the tick is every cycle.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package fifo_ser_pkg holds:
  - the state enum (IDLE..STOP, 3-bit encoding);
  - FRAME_START_BIT=0, FRAME_STOP_BIT=1, LINE_IDLE=1;
  - a function frame_len(DATA_W, PARITY_EN, BIT_CYCLES).
- One natural sub-module: ser_bit_timer. It is a BIT_CYCLES down-counter with a load input (restart at frame start) and a one-cycle tick output marking the bit boundary.

Test Plan:
- Reset: hold reset=0 for 3 cycles with the FIFO non-empty and en=1 -> sout=1, fifo_pop=0, busy=0, words_sent=0 throughout; first pop occurs 1 cycle after reset=1.
- Single word 16'hA5C3, defaults -> after start bit, sout bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then parity 0, then stop 1. Each bit lasts 4 cycles; frame_done once, 76 cycles after the start bit falls; words_sent=1.
- Word 16'h0001 with PARITY_EN=1 -> parity bit 1. Same word with PARITY_EN=0 -> no parity bit; frame is 72 cycles.
- Three words pushed, en=1 -> exactly 3 fifo_pop pulses; frames separated by exactly 2 cycles of sout=1 (POP+WAIT) after each stop bit; words_sent=3; no pop once fifo_empty=1.
- en dropped mid-DATA of frame 1 with 2 words queued -> frame 1 completes; no further fifo_pop until en=1 again.
- reset=0 asserted mid-DATA -> sout=1 on the next edge, words_sent=0. After release, the next queued word is sent as a complete frame.
